// File: rtl/soft_body_sequencer.sv
// soft_body_sequencer: per-frame scheduler sharing one soft-body updater across NUM_BODIES bodies.
module soft_body_sequencer #(
  parameter int NUM_BODIES = 3,
  parameter int NUM_NODES = 4,
  parameter int POSITION_SIZE = 16,
  parameter int VELOCITY_SIZE = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic [NUM_BODIES*NUM_NODES*POSITION_SIZE-1:0] init_x,
  input  logic [NUM_BODIES*NUM_NODES*POSITION_SIZE-1:0] init_y,
  input  logic begin_update,
  input  logic [NUM_BODIES-1:0] enable_mask,
  output logic upd_start,
  output logic [$clog2(NUM_BODIES):0] upd_body,
  output logic [NUM_NODES*POSITION_SIZE-1:0] upd_nodes_x,
  output logic [NUM_NODES*POSITION_SIZE-1:0] upd_nodes_y,
  output logic [NUM_NODES*VELOCITY_SIZE-1:0] upd_vel_x,
  output logic [NUM_NODES*VELOCITY_SIZE-1:0] upd_vel_y,
  input  logic node_valid_in,
  input  logic [POSITION_SIZE-1:0] node_x_in,
  input  logic [POSITION_SIZE-1:0] node_y_in,
  input  logic vel_valid_in,
  input  logic [VELOCITY_SIZE-1:0] vel_x_in,
  input  logic [VELOCITY_SIZE-1:0] vel_y_in,
  input  logic result_in,
  input  logic [$clog2(NUM_BODIES):0] rd_body,
  input  logic [$clog2(NUM_NODES):0] rd_node,
  output logic [POSITION_SIZE-1:0] rd_x,
  output logic [POSITION_SIZE-1:0] rd_y,
  output logic busy,
  output logic frame_done,
  output logic overrun,
  output logic count_error
);
  localparam int BW = $clog2(NUM_BODIES) + 1;
  localparam int NW = $clog2(NUM_NODES) + 1;
  localparam int PS = POSITION_SIZE;
  localparam int VS = VELOCITY_SIZE;
  typedef enum logic [2:0] {IDLE, SEEK, LAUNCH, WAIT, FINISH} state_t;
  state_t state;
  logic [NUM_BODIES-1:0] mask_q;
  logic [BW-1:0] cur;
  logic [NW-1:0] node_cnt, vel_cnt, node_next, vel_next;
  logic [PS-1:0] pos_x [NUM_BODIES][NUM_NODES];
  logic [PS-1:0] pos_y [NUM_BODIES][NUM_NODES];
  logic [VS-1:0] vel_x [NUM_BODIES][NUM_NODES];
  logic [VS-1:0] vel_y [NUM_BODIES][NUM_NODES];
  logic [PS-1:0] rd_x_nxt, rd_y_nxt;
  logic node_ok, vel_ok, cur_en;
  assign node_ok = node_valid_in && node_cnt != NW'(NUM_NODES);
  assign vel_ok = vel_valid_in && vel_cnt != NW'(NUM_NODES);
  assign node_next = node_cnt + NW'(node_ok);
  assign vel_next = vel_cnt + NW'(vel_ok);
  assign cur_en = |(mask_q & (NUM_BODIES'(1) << cur));
  always_comb begin
    upd_nodes_x = '0;
    upd_nodes_y = '0;
    upd_vel_x = '0;
    upd_vel_y = '0;
    rd_x_nxt = '0;
    rd_y_nxt = '0;
    for (int b = 0; b < NUM_BODIES; b++)
      for (int n = 0; n < NUM_NODES; n++) begin
        if (upd_body == BW'(b)) begin
          upd_nodes_x[n*PS +: PS] = pos_x[b][n];
          upd_nodes_y[n*PS +: PS] = pos_y[b][n];
          upd_vel_x[n*VS +: VS] = vel_x[b][n];
          upd_vel_y[n*VS +: VS] = vel_y[b][n];
        end
        if (rd_body == BW'(b) && rd_node == NW'(n)) begin
          rd_x_nxt = pos_x[b][n];
          rd_y_nxt = pos_y[b][n];
        end
      end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      mask_q <= '0;
      cur <= '0;
      node_cnt <= '0;
      vel_cnt <= '0;
      upd_start <= 1'b0;
      upd_body <= '0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
      count_error <= 1'b0;
      rd_x <= '0;
      rd_y <= '0;
      for (int b = 0; b < NUM_BODIES; b++)
        for (int n = 0; n < NUM_NODES; n++) begin
          pos_x[b][n] <= init_x[(b*NUM_NODES+n)*PS +: PS];
          pos_y[b][n] <= init_y[(b*NUM_NODES+n)*PS +: PS];
          vel_x[b][n] <= '0;
          vel_y[b][n] <= '0;
        end
    end else begin
      rd_x <= rd_x_nxt;
      rd_y <= rd_y_nxt;
      upd_start <= 1'b0;
      frame_done <= 1'b0;
      if (begin_update && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE:
          if (begin_update) begin
            mask_q <= enable_mask;
            cur <= '0;
            busy <= 1'b1;
            state <= SEEK;
          end
        SEEK:
          if (cur == BW'(NUM_BODIES)) begin
            frame_done <= 1'b1;
            state <= FINISH;
          end else if (!cur_en) begin
            cur <= cur + 1'b1;
          end else begin
            upd_start <= 1'b1;
            upd_body <= cur;
            state <= LAUNCH;
          end
        LAUNCH: begin
          node_cnt <= '0;
          vel_cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          node_cnt <= node_next;
          vel_cnt <= vel_next;
          for (int b = 0; b < NUM_BODIES; b++)
            for (int n = 0; n < NUM_NODES; n++)
              if (cur == BW'(b)) begin
                if (node_ok && node_cnt == NW'(n)) begin
                  pos_x[b][n] <= node_x_in;
                  pos_y[b][n] <= node_y_in;
                end
                if (vel_ok && vel_cnt == NW'(n)) begin
                  vel_x[b][n] <= vel_x_in;
                  vel_y[b][n] <= vel_y_in;
                end
              end
          if (result_in) begin
            if (node_next != NW'(NUM_NODES) || vel_next != NW'(NUM_NODES)) count_error <= 1'b1;
            cur <= cur + 1'b1;
            state <= SEEK;
          end
        end
        FINISH: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soft_body_sequencer.sv
// tb_soft_body_sequencer: randomized frames against a per-body position/velocity reference model.
module tb_soft_body_sequencer;
  localparam int NB = 3;
  localparam int NN = 4;
  localparam int PS = 16;
  localparam int VS = 16;
  localparam int BW = $clog2(NB) + 1;
  localparam int NW = $clog2(NN) + 1;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic [NB*NN*PS-1:0] init_x, init_y;
  logic begin_update = 1'b0;
  logic [NB-1:0] enable_mask = '0;
  logic upd_start;
  logic [BW-1:0] upd_body;
  logic [NN*PS-1:0] upd_nodes_x, upd_nodes_y;
  logic [NN*VS-1:0] upd_vel_x, upd_vel_y;
  logic node_valid_in = 1'b0;
  logic [PS-1:0] node_x_in = '0, node_y_in = '0;
  logic vel_valid_in = 1'b0;
  logic [VS-1:0] vel_x_in = '0, vel_y_in = '0;
  logic result_in = 1'b0;
  logic [BW-1:0] rd_body = '0;
  logic [NW-1:0] rd_node = '0;
  logic [PS-1:0] rd_x, rd_y;
  logic busy, frame_done, overrun, count_error;
  soft_body_sequencer #(.NUM_BODIES(NB), .NUM_NODES(NN), .POSITION_SIZE(PS), .VELOCITY_SIZE(VS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .init_x(init_x), .init_y(init_y),
    .begin_update(begin_update), .enable_mask(enable_mask),
    .upd_start(upd_start), .upd_body(upd_body),
    .upd_nodes_x(upd_nodes_x), .upd_nodes_y(upd_nodes_y),
    .upd_vel_x(upd_vel_x), .upd_vel_y(upd_vel_y),
    .node_valid_in(node_valid_in), .node_x_in(node_x_in), .node_y_in(node_y_in),
    .vel_valid_in(vel_valid_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
    .result_in(result_in), .rd_body(rd_body), .rd_node(rd_node),
    .rd_x(rd_x), .rd_y(rd_y), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .count_error(count_error)
  );
  always #5 clk_in = ~clk_in;
  int compared = 0;
  int mismatched = 0;
  logic [PS-1:0] i_x [NB][NN], i_y [NB][NN];
  logic [PS-1:0] m_x [NB][NN], m_y [NB][NN];
  logic [VS-1:0] m_vx [NB][NN], m_vy [NB][NN];
  logic [PS-1:0] ra_x [NB][NN], ra_y [NB][NN];
  bit m_cerr, m_ovr, timeout;
  int starts[$];
  int fd_cnt, mux_err;
  int full_n [NB] = '{NN, NN, NN};

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int n = 0; n < NN; n++) begin
        m_x[b][n] = i_x[b][n];
        m_y[b][n] = i_y[b][n];
        m_vx[b][n] = '0;
        m_vy[b][n] = '0;
      end
    m_cerr = 0;
    m_ovr = 0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic read_all();
    for (int b = 0; b < NB; b++)
      for (int n = 0; n < NN; n++) begin
        rd_body = BW'(b);
        rd_node = NW'(n);
        step();
        ra_x[b][n] = rd_x;
        ra_y[b][n] = rd_y;
      end
  endtask

  // Acts as the shared updater for one frame and records what the sequencer did.
  task automatic run_frame(input logic [NB-1:0] mask, input int nn [NB], input int nv [NB],
                           input bit sim, input bit pattern, input int ovr_body);
    int b, mx;
    bit fin;
    starts.delete();
    fd_cnt = 0;
    mux_err = 0;
    timeout = 0;
    fin = 0;
    enable_mask = mask;
    begin_update = 1'b1;
    step();
    begin_update = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (frame_done) fd_cnt++;
      if (!busy && fd_cnt > 0) fin = 1;
      else if (upd_start) begin
        b = int'(upd_body);
        starts.push_back(b);
        for (int n = 0; n < NN; n++)
          if (b < NB && (upd_nodes_x[n*PS +: PS] !== m_x[b][n] || upd_nodes_y[n*PS +: PS] !== m_y[b][n] ||
              upd_vel_x[n*VS +: VS] !== m_vx[b][n] || upd_vel_y[n*VS +: VS] !== m_vy[b][n])) mux_err++;
        step();
        mx = nn[b] > nv[b] ? nn[b] : nv[b];
        for (int k = 0; k < mx; k++) begin
          node_valid_in = k < nn[b];
          node_x_in = pattern ? PS'(10*b + k) : PS'($urandom);
          node_y_in = pattern ? PS'(1000 + 10*b + k) : PS'($urandom);
          vel_valid_in = k < nv[b];
          vel_x_in = VS'($urandom);
          vel_y_in = VS'($urandom);
          result_in = sim && k == mx - 1;
          begin_update = b == ovr_body && k == 0;
          step();
          if (k < nn[b] && k < NN) begin
            m_x[b][k] = node_x_in;
            m_y[b][k] = node_y_in;
          end
          if (k < nv[b] && k < NN) begin
            m_vx[b][k] = vel_x_in;
            m_vy[b][k] = vel_y_in;
          end
          if (begin_update) m_ovr = 1;
        end
        node_valid_in = 1'b0;
        vel_valid_in = 1'b0;
        begin_update = 1'b0;
        if (!(sim && mx > 0)) begin
          result_in = 1'b1;
          step();
        end
        result_in = 1'b0;
        if (nn[b] < NN || nv[b] < NN) m_cerr = 1;
      end else step();
    end
    if (!fin) timeout = 1;
  endtask

  task automatic check_frame(input string name, input logic [NB-1:0] mask);
    int exp_q[$];
    for (int b = 0; b < NB; b++) if (mask[b]) exp_q.push_back(b);
    compared++;
    if (timeout || fd_cnt != 1) begin
      mismatched++;
      $display("FAIL %s_done: timeout=%0d frame_done pulses=%0d, want 0/1", name, timeout, fd_cnt);
    end
    compared++;
    if (starts != exp_q) begin
      mismatched++;
      $display("FAIL %s_starts: got %p want %p", name, starts, exp_q);
    end
    compared++;
    if (mux_err != 0) begin
      mismatched++;
      $display("FAIL %s_mux: %0d updater view entries differ from model", name, mux_err);
    end
    compared++;
    if (count_error !== m_cerr || overrun !== m_ovr) begin
      mismatched++;
      $display("FAIL %s_flags: count_error=%b overrun=%b want %b/%b", name, count_error, overrun, m_cerr, m_ovr);
    end
    read_all();
    for (int b = 0; b < NB; b++)
      for (int n = 0; n < NN; n++) begin
        compared++;
        if (ra_x[b][n] !== m_x[b][n] || ra_y[b][n] !== m_y[b][n]) begin
          mismatched++;
          $display("FAIL %s_pos b%0d n%0d: got %h/%h want %h/%h", name, b, n, ra_x[b][n], ra_y[b][n], m_x[b][n], m_y[b][n]);
        end
      end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    compared++;
    if ({busy, frame_done, upd_start, overrun, count_error} !== 5'b0 || upd_body !== '0 || rd_x !== '0 || rd_y !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: busy=%b fd=%b start=%b ovr=%b cerr=%b body=%0d rd=%h/%h want all 0",
               busy, frame_done, upd_start, overrun, count_error, upd_body, rd_x, rd_y);
    end
    rst_in = 1'b0;
    model_reset();
    read_all();
    for (int b = 0; b < NB; b++)
      for (int n = 0; n < NN; n++) begin
        compared++;
        if (ra_x[b][n] !== i_x[b][n] || ra_y[b][n] !== i_y[b][n]) begin
          mismatched++;
          $display("FAIL reset_pos b%0d n%0d: got %h/%h want %h/%h", b, n, ra_x[b][n], ra_y[b][n], i_x[b][n], i_y[b][n]);
        end
      end
  endtask

  task automatic test_basic_frame();
    run_frame(3'b111, full_n, full_n, 0, 1, -1);
    check_frame("basic", 3'b111);
    rd_body = 2;
    rd_node = 3;
    step();
    compared++;
    if (rd_x !== 16'd23) begin
      mismatched++;
      $display("FAIL basic_rd23: got %0d want 23", rd_x);
    end
    rd_body = 3;
    rd_node = 0;
    step();
    compared++;
    if (rd_x !== '0 || rd_y !== '0) begin
      mismatched++;
      $display("FAIL rd_bad_body: got %h/%h want 0/0", rd_x, rd_y);
    end
    rd_body = 0;
    rd_node = 4;
    step();
    compared++;
    if (rd_x !== '0 || rd_y !== '0) begin
      mismatched++;
      $display("FAIL rd_bad_node: got %h/%h want 0/0", rd_x, rd_y);
    end
  endtask

  task automatic test_mask_skip();
    do_reset();
    run_frame(3'b101, full_n, full_n, 0, 0, -1);
    check_frame("mask_skip", 3'b101);
    for (int n = 0; n < NN; n++) begin
      compared++;
      if (ra_x[1][n] !== i_x[1][n] || ra_y[1][n] !== i_y[1][n]) begin
        mismatched++;
        $display("FAIL mask_skip_init n%0d: got %h/%h want %h/%h", n, ra_x[1][n], ra_y[1][n], i_x[1][n], i_y[1][n]);
      end
    end
  endtask

  task automatic test_all_masked();
    int starts_seen = 0;
    enable_mask = '0;
    begin_update = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      begin_update = 1'b0;
      if (upd_start) starts_seen++;
      compared++;
      if (busy !== (k <= 5) || frame_done !== (k == 5)) begin
        mismatched++;
        $display("FAIL all_masked_t%0d: busy=%b frame_done=%b want %b/%b", k, busy, frame_done, k <= 5, k == 5);
      end
    end
    compared++;
    if (starts_seen != 0) begin
      mismatched++;
      $display("FAIL all_masked_starts: got %0d want 0", starts_seen);
    end
  endtask

  task automatic test_simultaneous();
    run_frame(3'b111, full_n, full_n, 1, 0, -1);
    check_frame("simultaneous", 3'b111);
  endtask

  task automatic test_random(input int iters);
    logic [NB-1:0] mask;
    bit sim;
    for (int i = 0; i < iters; i++) begin
      mask = NB'($urandom);
      sim = 1'($urandom);
      run_frame(mask, full_n, full_n, sim, 0, -1);
      check_frame("random", mask);
    end
  endtask

  task automatic test_count_error();
    int short_n [NB] = '{3, NN, NN};
    int long_n [NB] = '{6, NN, NN};
    logic [PS-1:0] old_x;
    old_x = m_x[0][3];
    run_frame(3'b001, short_n, full_n, 0, 0, -1);
    check_frame("count_short", 3'b001);
    compared++;
    if (count_error !== 1'b1 || ra_x[0][3] !== old_x) begin
      mismatched++;
      $display("FAIL count_short_node3: count_error=%b x=%h want 1/%h", count_error, ra_x[0][3], old_x);
    end
    run_frame(3'b001, long_n, full_n, 0, 0, -1);
    check_frame("count_long", 3'b001);
  endtask

  task automatic test_overrun();
    run_frame(3'b111, full_n, full_n, 0, 0, 1);
    check_frame("overrun", 3'b111);
    compared++;
    if (overrun !== 1'b1) begin
      mismatched++;
      $display("FAIL overrun_flag: got %b want 1", overrun);
    end
  endtask

  task automatic test_midframe_reset();
    bit seen = 0;
    enable_mask = 3'b010;
    begin_update = 1'b1;
    step();
    begin_update = 1'b0;
    for (int c = 0; c < 20 && !seen; c++)
      if (upd_start) seen = 1;
      else step();
    compared++;
    if (!seen || upd_body !== BW'(1)) begin
      mismatched++;
      $display("FAIL midreset_launch: seen=%0d body=%0d want 1/1", seen, upd_body);
    end
    step();
    node_valid_in = 1'b1;
    node_x_in = PS'($urandom);
    node_y_in = PS'($urandom);
    step();
    node_valid_in = 1'b0;
    rst_in = 1'b1;
    step();
    compared++;
    if (busy !== 1'b0 || overrun !== 1'b0 || count_error !== 1'b0 || frame_done !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_flags: busy=%b ovr=%b cerr=%b fd=%b want 0", busy, overrun, count_error, frame_done);
    end
    rst_in = 1'b0;
    model_reset();
    read_all();
    for (int b = 0; b < NB; b++)
      for (int n = 0; n < NN; n++) begin
        compared++;
        if (ra_x[b][n] !== i_x[b][n] || ra_y[b][n] !== i_y[b][n]) begin
          mismatched++;
          $display("FAIL midreset_pos b%0d n%0d: got %h/%h want %h/%h", b, n, ra_x[b][n], ra_y[b][n], i_x[b][n], i_y[b][n]);
        end
      end
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int n = 0; n < NN; n++) begin
        i_x[b][n] = PS'($urandom);
        i_y[b][n] = PS'($urandom);
        init_x[(b*NN+n)*PS +: PS] = i_x[b][n];
        init_y[(b*NN+n)*PS +: PS] = i_y[b][n];
      end
    test_reset();
    test_basic_frame();
    test_mask_skip();
    test_all_masked();
    test_simultaneous();
    test_random(6);
    test_count_error();
    test_overrun();
    test_midframe_reset();
    test_random(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/soft_body_sequencer.md
Name: soft_body_sequencer

Overview:
- Owns position and velocity state for NUM_BODIES soft bodies (e.g. left wheel, right wheel, chassis), each with NUM_NODES nodes.
- On each physics tick it time-multiplexes one shared body updater across the enabled bodies in index order.
- It writes the streamed node and velocity results back into per-body storage and pulses frame_done when every enabled body has finished.
- It sits between the frame-tick source and the updater/renderer, generalising fixed two-wheel sequencing to N bodies with masking, overrun and error reporting.

Parameters:
- NUM_BODIES, 3, number of soft bodies sequenced (at least 1).
- NUM_NODES, 4, nodes per body (at least 1).
- POSITION_SIZE, 16, signed position width.
- VELOCITY_SIZE, 16, signed velocity width.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- init_x, init_y  in  NUM_BODIES*NUM_NODES*POSITION_SIZE  reset positions, flattened with body-major order (index b*NUM_NODES+n).
- begin_update  in  1  tick pulse that starts one frame.
- enable_mask  in  NUM_BODIES  bodies to update; sampled when the frame starts.
- upd_start  out  1  one-cycle start pulse to the shared updater.
- upd_body  out  $clog2(NUM_BODIES)+1  index of the body currently being served.
- upd_nodes_x, upd_nodes_y  out  NUM_NODES*POSITION_SIZE  current positions of body upd_body (combinational mux).
- upd_vel_x, upd_vel_y  out  NUM_NODES*VELOCITY_SIZE  current velocities of body upd_body.
- node_valid_in  in  1  one streamed node result is present.
- node_x_in, node_y_in  in  POSITION_SIZE  streamed node result.
- vel_valid_in  in  1  one streamed velocity result is present.
- vel_x_in, vel_y_in  in  VELOCITY_SIZE  streamed velocity result.
- result_in  in  1  updater finished the current body.
- rd_body  in  $clog2(NUM_BODIES)+1  render read select, body.
- rd_node  in  $clog2(NUM_NODES)+1  render read select, node.
- rd_x, rd_y  out  POSITION_SIZE  registered render read data.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- overrun  out  1  sticky: begin_update arrived while busy.
- count_error  out  1  sticky: a body finished with a node or velocity count other than NUM_NODES.

Behaviour:
- Reset:
  - pos[b][n] <= init values; vel <= 0; state IDLE.
  - upd_start, frame_done, busy, overrun, count_error, rd_x, rd_y <= 0; upd_body <= 0.
- States: IDLE, SEEK, LAUNCH, WAIT, FINISH.
- IDLE:
  - begin_update: latch enable_mask into mask_q, set cur=0, go to SEEK, busy=1 from the next cycle.
- SEEK (one cycle per body inspected):
  - cur==NUM_BODIES: go to FINISH.
  - mask_q[cur]==0: cur++ and stay in SEEK.
  - Otherwise: go to LAUNCH.
- LAUNCH:
  - upd_start=1 for exactly this cycle, upd_body=cur.
  - Clear node_cnt and vel_cnt; go to WAIT.
- WAIT:
  - node_valid_in: pos[cur][node_cnt] <= input, node_cnt++.
  - vel_valid_in: vel[cur][vel_cnt] <= input, vel_cnt++.
  - Both valids in the same cycle are legal and independent.
  - Writes with a counter already at NUM_NODES are discarded; the counter saturates.
  - result_in: if node_cnt!=NUM_NODES or vel_cnt!=NUM_NODES, set count_error. Then cur++ and go to SEEK.
  - A valid arriving in the same cycle as result_in is written first; the count check includes it.
- FINISH:
  - frame_done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
  - All bodies masked: begin_update at cycle t gives frame_done at t+NUM_BODIES+2.
- Updater I/O:
  - upd_nodes/upd_vel reflect storage combinationally, so writes become visible the cycle after they are captured.
  - Inputs (valids, result_in) are ignored outside WAIT.
- Overrun: begin_update while state!=IDLE sets overrun and is otherwise dropped; the current frame is unaffected. begin_update in the FINISH cycle counts as overrun.
- Render read: rd_x/rd_y <= pos[rd_body][rd_node] with 1-cycle latency. Out-of-range indices return 0. The read may see a write from the same cycle only one cycle later, i.e. old data.
- Reset mid-frame: the frame is aborted immediately, all state and sticky flags clear, and positions reload from init_x/init_y.
- Sticky flags clear only on reset.

Test Plan:
- Basic frame: NUM_BODIES=3, mask=3'b111, updater model streams 4 nodes and 4 velocities per body (body b node n x=10*b+n) and then result.
  - Required: exactly 3 upd_start pulses with upd_body 0,1,2.
  - Required: rd of body 2 node 3 returns x=23.
  - Required: frame_done is a single pulse; count_error=0.
- Mask skip: mask=3'b101.
  - Required: upd_start only for bodies 0 and 2.
  - Required: body 1 positions equal their init values after the frame.
- All masked: mask=0, begin_update at cycle 10.
  - Required: no upd_start; frame_done at cycle 15; busy high on cycles 11-15.
- Count error: the updater sends 3 nodes then result.
  - Required: count_error=1; node 3 retains its old value; the frame still completes.
  - Then send 6 nodes: nodes 4 and 5 are discarded and count_error stays 1.
- Overrun and mid-frame reset:
  - begin_update during WAIT: overrun=1; the frame completes normally with 3 starts.
  - rst_in asserted during WAIT of body 1: the next cycle has busy=0, overrun=0, and pos equals init.
- Simultaneous valid and result: the 4th node_valid_in coincides with result_in.
  - Required: the node is written and count_error=0.
